// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: operation codes,
// FSM state encoding and the quotient returned on a divide by zero.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Divide-by-zero quotient: all ones, sliced to the configured width.
  localparam int            DIV0_MAX_W = 64;
  localparam logic [63:0]   DIV0_QUOT  = '1;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative datapath.
//   multiply: right-shifting shift-add on {partial_hi, multiplier}
//   divide  : restoring step on {remainder, dividend/quotient}
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  i_is_div,
  input  logic [2*DATA_W-1:0]   i_acc,
  input  logic [DATA_W-1:0]     i_opnd,
  output logic [2*DATA_W-1:0]   o_acc
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_trial;
  logic [DATA_W:0] w_diff;

  // Compute both step flavours and pick the one for the current op class.
  always_comb begin
    w_sum   = {1'b0, i_acc[2*DATA_W-1:DATA_W]} +
              (i_acc[0] ? {1'b0, i_opnd} : {(DATA_W+1){1'b0}});
    w_trial = {i_acc[2*DATA_W-1:DATA_W], i_acc[DATA_W-1]};
    w_diff  = w_trial - {1'b0, i_opnd};
    o_acc   = {w_sum, i_acc[DATA_W-1:1]};
    if (i_is_div) begin
      // Bit DATA_W of the difference is set exactly when trial < divisor.
      if (!w_diff[DATA_W]) begin
        o_acc = {w_diff[DATA_W-1:0], i_acc[DATA_W-2:0], 1'b1};
      end else begin
        o_acc = {w_trial[DATA_W-1:0], i_acc[DATA_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair.
// Optional build macro MULDIV_FAST_MUL_EN: MULT/MULTU finish on the accept
// edge using a combinational product; divides stay iterative.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_src_a,
  input  logic [DATA_W-1:0] i_src_b,
  input  logic              i_hi_wen,
  input  logic              i_lo_wen,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  state_e                r_state;
  state_e                w_state_nxt;
  op_e                   r_op;
  logic [2*DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]     r_opnd;
  logic [DATA_W-1:0]     r_a_raw;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic                  r_divz;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_W-1:0]     r_hi;
  logic [DATA_W-1:0]     r_lo;
  logic                  r_done;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_fast_mul;
  logic                  w_signed_in;
  logic                  w_a_neg;
  logic                  w_b_neg;
  logic [DATA_W-1:0]     w_abs_a;
  logic [DATA_W-1:0]     w_abs_b;
  logic [2*DATA_W-1:0]   w_step_acc;
  logic [DATA_W-1:0]     w_res_hi;
  logic [DATA_W-1:0]     w_res_lo;

  function automatic logic [DATA_W-1:0] f_neg_w(input logic [DATA_W-1:0] x);
    return (~x) + DATA_W'(1);
  endfunction

  function automatic logic [2*DATA_W-1:0] f_neg_2w(input logic [2*DATA_W-1:0] x);
    return (~x) + (2*DATA_W)'(1);
  endfunction

  assign w_accept    = (r_state == ST_IDLE) && i_start;
  assign w_last      = (r_state == ST_RUN) && (r_cnt == CNT_W'(DATA_W-1));
  assign w_signed_in = ~i_op[0];
  assign w_a_neg     = w_signed_in & i_src_a[DATA_W-1];
  assign w_b_neg     = w_signed_in & i_src_b[DATA_W-1];
  assign w_abs_a     = w_a_neg ? f_neg_w(i_src_a) : i_src_a;
  assign w_abs_b     = w_b_neg ? f_neg_w(i_src_b) : i_src_b;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [DATA_W:0]     w_fa;
  logic signed [DATA_W:0]     w_fb;
  logic signed [2*DATA_W+1:0] w_fprod;
  assign w_fast_mul = ~i_op[1];
  assign w_fa       = {w_a_neg, i_src_a};
  assign w_fb       = {w_b_neg, i_src_b};
  assign w_fprod    = w_fa * w_fb;
`else
  assign w_fast_mul = 1'b0;
`endif

  muldiv_step #(.DATA_W(DATA_W)) u_step (
    .i_is_div (r_op[1]),
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .o_acc    (w_step_acc)
  );

  // Next-state decode; start is only looked at in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_state_nxt = w_fast_mul ? ST_DONE : ST_RUN;
      ST_RUN:  if (w_last)  w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Apply sign correction / divide-by-zero override to the final iteration.
  always_comb begin
    w_res_hi = w_step_acc[2*DATA_W-1:DATA_W];
    w_res_lo = w_step_acc[DATA_W-1:0];
    if (r_op[1]) begin
      if (r_divz) begin
        w_res_hi = r_a_raw;
        w_res_lo = DIV0_QUOT[DATA_W-1:0];
      end else begin
        if (r_neg_q) w_res_lo = f_neg_w(w_step_acc[DATA_W-1:0]);
        if (r_neg_r) w_res_hi = f_neg_w(w_step_acc[2*DATA_W-1:DATA_W]);
      end
    end else if (r_neg_q) begin
      {w_res_hi, w_res_lo} = f_neg_2w(w_step_acc);
    end
  end

  // State register and registered done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Operand capture at accept, one iteration per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= OP_MULT;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_a_raw <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_divz  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_op    <= op_e'(i_op);
      r_cnt   <= '0;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_divz  <= i_op[1] && (i_src_b == '0);
      r_a_raw <= i_src_a;
      if (i_op[1]) begin
        r_acc  <= {{DATA_W{1'b0}}, w_abs_a};
        r_opnd <= w_abs_b;
      end else begin
        r_acc  <= {{DATA_W{1'b0}}, w_abs_b};
        r_opnd <= w_abs_a;
      end
    end else if (r_state == ST_RUN) begin
      r_acc <= w_step_acc;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // HI/LO: op result on completion, MTHI/MTLO only when idle and not starting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_last) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
`ifdef MULDIV_FAST_MUL_EN
    end else if (w_accept && w_fast_mul) begin
      {r_hi, r_lo} <= w_fprod[2*DATA_W-1:0];
`endif
    end else if ((r_state == ST_IDLE) && !i_start) begin
      if (i_hi_wen) r_hi <= i_wdata;
      if (i_lo_wen) r_lo <= i_wdata;
    end
  end

  assign o_busy = (r_state != ST_IDLE);
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized + directed bench for muldiv_unit against a plain-arithmetic model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [1:0]  i_op;
  logic [31:0] i_src_a;
  logic [31:0] i_src_b;
  logic        i_hi_wen;
  logic        i_lo_wen;
  logic [31:0] i_wdata;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  muldiv_unit #(.DATA_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_start),
    .i_op     (i_op),
    .i_src_a  (i_src_a),
    .i_src_b  (i_src_b),
    .i_hi_wen (i_hi_wen),
    .i_lo_wen (i_lo_wen),
    .i_wdata  (i_wdata),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_hi     (o_hi),
    .o_lo     (o_lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {hi, lo} the MIPS ISA defines for each operation.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'b00: return sa * sb;
      2'b01: return ua * ub;
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == 2'b10) begin
          sq = sa / sb;
          sr = sa % sb;
          return {sr[31:0], sq[31:0]};
        end
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return $urandom_range(0, 255);
      default: return $urandom;
    endcase
  endfunction

  // Launch one op, follow it to completion, check latency, busy span and result.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit with_wen, input bit interfere, input string tag);
    logic [63:0] exp;
    int k, busy_n, exp_k;
    bit got, held;
    exp   = ref_model(op, a, b);
    exp_k = 32;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[1]) exp_k = 0;
`endif
    @(negedge clk);
    i_start = 1'b1; i_op = op; i_src_a = a; i_src_b = b;
    if (with_wen) begin
      i_hi_wen = 1'b1; i_lo_wen = 1'b1; i_wdata = 32'hDEAD_BEEF;
    end
    @(posedge clk);
    #1;
    i_start = 1'b0; i_hi_wen = 1'b0; i_lo_wen = 1'b0;
    i_src_a = $urandom; i_src_b = $urandom;
    k = 0; busy_n = 0; got = 0; held = 1;
    while (k < 100) begin
      @(negedge clk);
      if (o_busy) busy_n++;
      if (o_done) begin
        got = 1;
        break;
      end
      if (o_hi !== m_hi || o_lo !== m_lo) held = 0;
      if (interfere && k == 5) begin
        i_start = 1'b1; i_op = 2'b01; i_src_a = 32'd9; i_src_b = 32'd9;
        i_hi_wen = 1'b1; i_lo_wen = 1'b1; i_wdata = 32'h5555_AAAA;
      end else if (interfere && k == 6) begin
        i_start = 1'b0; i_hi_wen = 1'b0; i_lo_wen = 1'b0;
      end
      k++;
    end
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    check({tag, "_latency"}, 64'(k), 64'(exp_k));
    check({tag, "_result"}, {o_hi, o_lo}, exp);
    check({tag, "_hold_during_run"}, 64'(held), 64'd1);
    @(negedge clk);
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_k + 1));
    check({tag, "_idle_after"}, {62'd0, o_busy, o_done}, 64'd0);
    {m_hi, m_lo} = exp;
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_op = 2'b00; i_src_a = '0; i_src_b = '0;
    i_hi_wen = 1'b0; i_lo_wen = 1'b0; i_wdata = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    check("reset_state", {30'd0, o_busy, o_done, o_hi, o_lo}, 64'd0);
    rst = 1'b0;

    // Directed corner cases
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "multu_max");
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7,         0, 0, "mult_neg3x7");
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, 0, "mult_minxmin");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2,         0, 0, "div_neg7by2");
    run_op(2'b11, 32'd7,         32'd0,         0, 0, "divu_by0");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0,         0, 0, "div_by0");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div_min_by_m1");
    run_op(2'b11, 32'd100,       32'd7,         0, 0, "divu_100by7");
    run_op(2'b11, 32'd1000,      32'd33,        0, 1, "divu_ignore_start");

    // Asynchronous reset in the middle of an op
    @(negedge clk);
    i_start = 1'b1; i_op = 2'b11; i_src_a = 32'd12345; i_src_b = 32'd3;
    @(posedge clk);
    #1 i_start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset_mid_op", {30'd0, o_busy, o_done, o_hi, o_lo}, 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    run_op(2'b01, 32'd3, 32'd4, 0, 0, "multu_after_reset");

    // MTHI / MTLO while idle
    @(negedge clk);
    i_hi_wen = 1'b1; i_wdata = 32'h1234_5678;
    @(negedge clk);
    i_hi_wen = 1'b0;
    m_hi = 32'h1234_5678;
    check("mthi_idle", {o_hi, o_lo}, {m_hi, m_lo});
    i_lo_wen = 1'b1; i_hi_wen = 1'b1; i_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    i_lo_wen = 1'b0; i_hi_wen = 1'b0;
    m_hi = 32'hCAFE_F00D; m_lo = 32'hCAFE_F00D;
    check("mthi_mtlo_both", {o_hi, o_lo}, {m_hi, m_lo});
    run_op(2'b00, 32'd6, 32'hFFFF_FFFE, 1, 0, "start_beats_wen");

    // Randomized ops
    for (int i = 0; i < 30; i++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick(), bit'($urandom_range(0, 1)),
             0, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
